// File: rtl/lane_queue_bank.sv
// Multi-lane saturating car queue tracker with per-lane departure pacing, drop flags and aggregates.
// Optional per-lane wait timer and alarm enabled by defining WAIT_TIMER_EN.
module lane_queue_bank #(
  parameter int unsigned NUM_LANES  = 4,
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned MAX_CARS   = 15,
  parameter int unsigned DEPART_GAP = 1,
`ifdef WAIT_TIMER_EN
  parameter int unsigned WAIT_W     = 8,
  parameter int unsigned WAIT_LIMIT = 200,
`endif
  localparam int unsigned TOT_W = CNT_W + $clog2(NUM_LANES + 1),
  localparam int unsigned IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                         traffic_clk,
  input  logic                         reset,
  input  logic [NUM_LANES-1:0]         add_car,
  input  logic [NUM_LANES-1:0]         dec_car,
  input  logic                         clr_drop,
  output logic [NUM_LANES*CNT_W-1:0]   car_queue_counter,
  output logic [NUM_LANES-1:0]         car_in_queue,
  output logic [NUM_LANES-1:0]         queue_full,
  output logic [NUM_LANES-1:0]         depart_ack,
  output logic [NUM_LANES-1:0]         drop_flag,
  output logic [TOT_W-1:0]             total_cars,
  output logic [IDX_W-1:0]             busiest_lane,
  output logic                         busiest_valid
`ifdef WAIT_TIMER_EN
  ,
  output logic [NUM_LANES*WAIT_W-1:0]  wait_cycles,
  output logic [NUM_LANES-1:0]         wait_alarm
`endif
);

  localparam int unsigned GAP_W = (DEPART_GAP > 1) ? $clog2(DEPART_GAP) : 1;

  logic [CNT_W-1:0]     cnt_q [NUM_LANES];
  logic [CNT_W-1:0]     cnt_d [NUM_LANES];
  logic [GAP_W-1:0]     gap_q [NUM_LANES];
  logic [GAP_W-1:0]     gap_d [NUM_LANES];
  logic [NUM_LANES-1:0] ack_q, ack_d, drop_q, drop_d;
  logic [NUM_LANES-1:0] dep_ok, arr_ok;
  logic [TOT_W-1:0]     total_q, total_d;
  logic [IDX_W-1:0]     busiest_q, busiest_d;
  logic                 valid_q, valid_d;
  logic [CNT_W-1:0]     best_cnt;

  // Per-lane acceptance; a departure frees the slot an arrival on a full lane needs.
  always_comb begin
    dep_ok = '0;
    arr_ok = '0;
    ack_d  = '0;
    drop_d = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      cnt_d[i] = cnt_q[i];
      gap_d[i] = gap_q[i];
      dep_ok[i] = dec_car[i] && (cnt_q[i] != '0) && (gap_q[i] == '0);
      arr_ok[i] = add_car[i] && ((cnt_q[i] < CNT_W'(MAX_CARS)) || dep_ok[i]);
      case ({arr_ok[i], dep_ok[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + CNT_W'(1);
        2'b01:   cnt_d[i] = cnt_q[i] - CNT_W'(1);
        default: cnt_d[i] = cnt_q[i];
      endcase
      if (dep_ok[i]) begin
        gap_d[i] = GAP_W'(DEPART_GAP - 1);
      end else if (gap_q[i] != '0) begin
        gap_d[i] = gap_q[i] - GAP_W'(1);
      end
      ack_d[i]  = dep_ok[i];
      drop_d[i] = (add_car[i] && !arr_ok[i]) || (drop_q[i] && !clr_drop);
    end
  end

  // Aggregates from the registered counts; strict compare keeps the lowest index on ties.
  always_comb begin
    total_d   = '0;
    busiest_d = '0;
    best_cnt  = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      total_d = total_d + TOT_W'(cnt_q[i]);
      if (cnt_q[i] > best_cnt) begin
        best_cnt  = cnt_q[i];
        busiest_d = IDX_W'(i);
      end
    end
    valid_d = (total_d != '0);
  end

  always_ff @(posedge traffic_clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        cnt_q[i] <= '0;
        gap_q[i] <= '0;
      end
      ack_q     <= '0;
      drop_q    <= '0;
      total_q   <= '0;
      busiest_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        cnt_q[i] <= cnt_d[i];
        gap_q[i] <= gap_d[i];
      end
      ack_q     <= ack_d;
      drop_q    <= drop_d;
      total_q   <= total_d;
      busiest_q <= busiest_d;
      valid_q   <= valid_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      car_queue_counter[i*CNT_W +: CNT_W] = cnt_q[i];
      car_in_queue[i] = (cnt_q[i] != '0);
      queue_full[i]   = (cnt_q[i] == CNT_W'(MAX_CARS));
    end
  end

  assign depart_ack    = ack_q;
  assign drop_flag     = drop_q;
  assign total_cars    = total_q;
  assign busiest_lane  = busiest_q;
  assign busiest_valid = valid_q;

`ifdef WAIT_TIMER_EN
  logic [WAIT_W-1:0] wait_q [NUM_LANES];
  logic [WAIT_W-1:0] wait_d [NUM_LANES];

  // Wait timer restarts whenever the lane drains or a car leaves.
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      wait_d[i] = wait_q[i];
      if ((cnt_d[i] == '0) || dep_ok[i]) begin
        wait_d[i] = '0;
      end else if ((cnt_q[i] != '0) && (wait_q[i] != '1)) begin
        wait_d[i] = wait_q[i] + WAIT_W'(1);
      end
    end
  end

  always_ff @(posedge traffic_clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_LANES; i++) wait_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) wait_q[i] <= wait_d[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      wait_cycles[i*WAIT_W +: WAIT_W] = wait_q[i];
      wait_alarm[i] = (32'(wait_q[i]) >= WAIT_LIMIT);
    end
  end
`endif

endmodule

// File: tb/tb_lane_queue_bank.sv
// Self-checking bench for lane_queue_bank: default instance (gap 1) plus a paced instance (gap 3).
module tb_lane_queue_bank;

  logic        traffic_clk;
  logic        reset;
  logic [3:0]  add_a, dec_a, add_g, dec_g;
  logic        clr_a;
  logic [15:0] cnt_a, cnt_g;
  logic [3:0]  inq_a, full_a, ack_a, drop_a, inq_g, full_g, ack_g, drop_g;
  logic [6:0]  tot_a, tot_g;
  logic [1:0]  bus_a, bus_g;
  logic        bv_a, bv_g;
`ifdef WAIT_TIMER_EN
  logic [31:0] wc_a, wc_g;
  logic [3:0]  wal_a, wal_g;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  add;
    logic [3:0]  dec;
    logic        clr;
    logic [15:0] cnt;
    logic [3:0]  ack;
    logic [3:0]  drop;
  } vec_t;

  typedef struct {
    logic [15:0] cnt;
    logic [3:0]  ack;
    logic [3:0]  drop;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  lane_queue_bank `ifdef WAIT_TIMER_EN #(.WAIT_LIMIT(10)) `endif dut (
    .traffic_clk(traffic_clk), .reset(reset), .add_car(add_a), .dec_car(dec_a),
    .clr_drop(clr_a), .car_queue_counter(cnt_a), .car_in_queue(inq_a), .queue_full(full_a),
    .depart_ack(ack_a), .drop_flag(drop_a), .total_cars(tot_a), .busiest_lane(bus_a),
    .busiest_valid(bv_a)
`ifdef WAIT_TIMER_EN
    , .wait_cycles(wc_a), .wait_alarm(wal_a)
`endif
  );

  lane_queue_bank #(.DEPART_GAP(3)) dut_g (
    .traffic_clk(traffic_clk), .reset(reset), .add_car(add_g), .dec_car(dec_g),
    .clr_drop(1'b0), .car_queue_counter(cnt_g), .car_in_queue(inq_g), .queue_full(full_g),
    .depart_ack(ack_g), .drop_flag(drop_g), .total_cars(tot_g), .busiest_lane(bus_g),
    .busiest_valid(bv_g)
`ifdef WAIT_TIMER_EN
    , .wait_cycles(wc_g), .wait_alarm(wal_g)
`endif
  );

  initial traffic_clk = 1'b0;
  always #5 traffic_clk = ~traffic_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge traffic_clk);
    #1;
  endtask

  task automatic idle_inputs();
    add_a = '0; dec_a = '0; clr_a = 1'b0; add_g = '0; dec_g = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    exp_t e;
    // Lane1 to 5, then simultaneous add/dec on lane1, full-lane add+dec on lane0, lane2 empty corners.
    for (int k = 1; k <= 5; k++)
      vecs.push_back('{4'b0010, 4'b0000, 1'b0, 16'h000F | 16'(k << 4), 4'b0000, 4'b0000});
    for (int k = 0; k < 10; k++)
      vecs.push_back('{4'b0010, 4'b0010, 1'b0, 16'h005F, 4'b0010, 4'b0000});
    vecs.push_back('{4'b0001, 4'b0001, 1'b0, 16'h005F, 4'b0001, 4'b0000});
    vecs.push_back('{4'b0100, 4'b0100, 1'b0, 16'h015F, 4'b0000, 4'b0000});
    vecs.push_back('{4'b0000, 4'b0100, 1'b0, 16'h005F, 4'b0100, 4'b0000});
    vecs.push_back('{4'b0000, 4'b0100, 1'b0, 16'h005F, 4'b0000, 4'b0000});
    vecs.push_back('{4'b0000, 4'b0100, 1'b0, 16'h005F, 4'b0000, 4'b0000});

    do_reset();
    chk("rst_cnt", 32'(cnt_a), 0);
    chk("rst_inq", 32'(inq_a), 0);
    chk("rst_full", 32'(full_a), 0);
    chk("rst_ack", 32'(ack_a), 0);
    chk("rst_drop", 32'(drop_a), 0);
    chk("rst_total", 32'(tot_a), 0);
    chk("rst_busiest", 32'(bus_a), 0);
    chk("rst_valid", 32'(bv_a), 0);

    // Lane0 fills to saturation and then drops arrivals.
    add_a = 4'b0001;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk("t1_cnt0", 32'(cnt_a[3:0]), (k < 15) ? k : 15);
      chk("t1_full0", 32'(full_a[0]), (k >= 15) ? 1 : 0);
      chk("t1_drop0", 32'(drop_a[0]), (k >= 16) ? 1 : 0);
      chk("t1_total", 32'(tot_a), (k - 1 < 15) ? k - 1 : 15);
      chk("t1_valid", 32'(bv_a), (k >= 2) ? 1 : 0);
    end
    clr_a = 1'b1;
    tick();
    chk("drop_set_wins", 32'(drop_a[0]), 1);
    add_a = '0;
    tick();
    chk("drop_cleared", 32'(drop_a), 0);
    clr_a = 1'b0;

    foreach (vecs[n]) begin
      add_a = vecs[n].add;
      dec_a = vecs[n].dec;
      clr_a = vecs[n].clr;
      sb.push_back('{vecs[n].cnt, vecs[n].ack, vecs[n].drop});
      tick();
      if (sb.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        e = sb.pop_front();
        chk($sformatf("vec%0d_cnt", n), 32'(cnt_a), 32'(e.cnt));
        chk($sformatf("vec%0d_ack", n), 32'(ack_a), 32'(e.ack));
        chk($sformatf("vec%0d_drop", n), 32'(drop_a), 32'(e.drop));
      end
    end
    idle_inputs();

    // Paced departures on the gap-3 instance.
    add_g = 4'b1000;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("t4_fill", 32'(cnt_g[15:12]), k);
    end
    add_g = '0;
    dec_g = 4'b1000;
    for (int c = 0; c < 9; c++) begin
      tick();
      chk($sformatf("t4_ack_c%0d", c), 32'(ack_g[3]), (c % 3 == 0) ? 1 : 0);
      chk($sformatf("t4_cnt_c%0d", c), 32'(cnt_g[15:12]), 6 - (c / 3 + 1));
    end
    dec_g = '0;

    // Aggregates with a tie between lanes 1 and 2, then reset mid-stream.
    do_reset();
    for (int k = 1; k <= 7; k++) begin
      add_a = {(k <= 2), 1'b1, 1'b1, (k <= 4)};
      tick();
    end
    add_a = '0;
    chk("t5_total_lag", 32'(tot_a), 18);
    tick();
    chk("t5_cnt", 32'(cnt_a), 32'h2774);
    chk("t5_total", 32'(tot_a), 20);
    chk("t5_busiest", 32'(bus_a), 1);
    chk("t5_valid", 32'(bv_a), 1);
    reset = 1'b1;
    add_a = 4'b1111;
    tick();
    chk("t5_rst_cnt", 32'(cnt_a), 0);
    chk("t5_rst_inq", 32'(inq_a), 0);
    chk("t5_rst_full", 32'(full_a), 0);
    chk("t5_rst_total", 32'(tot_a), 0);
    chk("t5_rst_busiest", 32'(bus_a), 0);
    chk("t5_rst_valid", 32'(bv_a), 0);
    reset = 1'b0;
    idle_inputs();

`ifdef WAIT_TIMER_EN
    do_reset();
    add_a = 4'b0001;
    tick();
    add_a = '0;
    chk("t6_wait_start", 32'(wc_a[7:0]), 0);
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("t6_wait", 32'(wc_a[7:0]), k);
      chk("t6_alarm", 32'(wal_a[0]), (k >= 10) ? 1 : 0);
    end
    dec_a = 4'b0001;
    tick();
    dec_a = '0;
    chk("t6_wait_clear", 32'(wc_a[7:0]), 0);
    chk("t6_alarm_clear", 32'(wal_a[0]), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
